// File: rtl/urv_pipe_ctrl.sv
// Pipeline control for the uRV core: per-stage stall fan-out, branch kill and halt/drain FSM.
// Latency: stall_o/kill_o are combinational; hold_fetch_o/halted_o/drain_timeout_o are registered state decodes.
// Backpressure: a stall request freezes every older stage; a stalled branch stage freezes the branch history.
module urv_pipe_ctrl #(
  parameter int                      g_num_stages      = 4,
  parameter int                      g_bra_stage       = 2,
  parameter int                      g_bra_kill_depth  = 3,
  parameter logic [g_num_stages-1:0] g_self_stall_mask = g_num_stages'(4'b0100),
  parameter int                      g_drain_timeout   = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [g_num_stages-1:0] stall_req_i,
  input  logic [g_num_stages-1:0] valid_i,
  input  logic                    bra_i,
  input  logic                    halt_req_i,
  input  logic                    resume_i,
  output logic [g_num_stages-1:0] stall_o,
  output logic [g_num_stages-1:0] kill_o,
  output logic                    hold_fetch_o,
  output logic                    halted_o,
  output logic                    drain_timeout_o
);

  localparam int c_cnt_w = $clog2(g_drain_timeout + 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  state_t               state_q, state_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic                 tmo_q, tmo_d;
  logic                 pipe_empty;
  // Bit 0 is the current branch, bits above are the history (youngest first).
  logic [g_bra_kill_depth-1:0] kill_src;
  // Fetch validity never blocks a drain: fetch is held, so its slot is irrelevant.
  logic                 unused_valid0;

  assign unused_valid0 = valid_i[0];

  // A stage stalls when any younger-index (downstream) stage requests, or on its own request if masked in.
  always_comb begin
    stall_o = '0;
    for (int s = 0; s < g_num_stages; s++) begin
      stall_o[s] = stall_req_i[s] & g_self_stall_mask[s];
      for (int k = s + 1; k < g_num_stages; k++) begin
        stall_o[s] = stall_o[s] | stall_req_i[k];
      end
    end
  end

  if (g_bra_kill_depth > 1) begin : g_hist
    logic [g_bra_kill_depth-2:0] hist_q;

    assign kill_src = {hist_q, bra_i};

    // Branch history shifts only while the branch stage advances.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        hist_q <= '0;
      end else if (!stall_o[g_bra_stage]) begin
        hist_q <= kill_src[g_bra_kill_depth-2:0];
      end
    end
  end else begin : g_no_hist
    assign kill_src = bra_i;
  end

  // Stage s at or before the branch stage is killed for as many history terms as it is close to the branch.
  always_comb begin
    kill_o = '0;
    for (int s = 0; s <= g_bra_stage; s++) begin
      for (int j = 0; j < g_bra_kill_depth; j++) begin
        if (j < g_bra_kill_depth - (g_bra_stage - s)) begin
          kill_o[s] = kill_o[s] | kill_src[j];
        end
      end
    end
    if (rst_i) begin
      kill_o = '1;
    end
  end

  assign pipe_empty = (valid_i[g_num_stages-1:1] == '0) && (stall_req_i == '0);

  // Halt FSM next state: a started drain always completes, either empty or by timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_RUN: begin
        if (halt_req_i) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
          tmo_d   = 1'b0;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (pipe_empty) begin
          state_d = ST_HALTED;
        end else if (cnt_q == c_cnt_w'(g_drain_timeout)) begin
          state_d = ST_HALTED;
          tmo_d   = 1'b1;
        end
      end
      ST_HALTED: begin
        if (resume_i) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Halt FSM state, drain counter and sticky timeout flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Reset forces the status outputs low even while the state register still holds a pre-reset value.
  assign hold_fetch_o    = ~rst_i & (state_q != ST_RUN);
  assign halted_o        = ~rst_i & (state_q == ST_HALTED);
  assign drain_timeout_o = ~rst_i & tmo_q;

endmodule

// File: tb/tb_urv_pipe_ctrl.sv
// Directed bench for urv_pipe_ctrl (4 stages, branch stage 2, kill depth 3, drain timeout 5).
// Each step drives inputs after a rising edge, queues the expected outputs and checks them on the falling edge.
// Expected values are written out by hand from the intended behaviour.
module tb_urv_pipe_ctrl;

  typedef struct {
    string      tag;
    logic [3:0] stall;
    logic [3:0] kill;
    logic       hold;
    logic       halted;
    logic       tmo;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] stall_req_i;
  logic [3:0] valid_i;
  logic       bra_i;
  logic       halt_req_i;
  logic       resume_i;
  logic [3:0] stall_o;
  logic [3:0] kill_o;
  logic       hold_fetch_o;
  logic       halted_o;
  logic       drain_timeout_o;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  urv_pipe_ctrl #(
    .g_num_stages     (4),
    .g_bra_stage      (2),
    .g_bra_kill_depth (3),
    .g_self_stall_mask(4'b0100),
    .g_drain_timeout  (5)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .stall_req_i    (stall_req_i),
    .valid_i        (valid_i),
    .bra_i          (bra_i),
    .halt_req_i     (halt_req_i),
    .resume_i       (resume_i),
    .stall_o        (stall_o),
    .kill_o         (kill_o),
    .hold_fetch_o   (hold_fetch_o),
    .halted_o       (halted_o),
    .drain_timeout_o(drain_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cmp(input string tag, input string fld, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s %s observed=%b expected=%b", tag, fld, got, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    n_vec++;
    assert (exp_q.size() > 0)
    else begin
      n_err++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp(e.tag, "stall_o", stall_o, e.stall);
      cmp(e.tag, "kill_o", kill_o, e.kill);
      cmp(e.tag, "hold_fetch_o", {3'b000, hold_fetch_o}, {3'b000, e.hold});
      cmp(e.tag, "halted_o", {3'b000, halted_o}, {3'b000, e.halted});
      cmp(e.tag, "drain_timeout_o", {3'b000, drain_timeout_o}, {3'b000, e.tmo});
    end
  endtask

  task automatic step(input string tag, input logic r, input logic [3:0] sreq, input logic [3:0] vld,
                      input logic b, input logic h, input logic res,
                      input logic [3:0] e_stall, input logic [3:0] e_kill,
                      input logic e_hold, input logic e_halted, input logic e_tmo);
    exp_t e;
    rst_i       = r;
    stall_req_i = sreq;
    valid_i     = vld;
    bra_i       = b;
    halt_req_i  = h;
    resume_i    = res;
    e.tag = tag; e.stall = e_stall; e.kill = e_kill;
    e.hold = e_hold; e.halted = e_halted; e.tmo = e_tmo;
    exp_q.push_back(e);
    @(negedge clk_i);
    check_out();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; stall_req_i = '0; valid_i = '0; bra_i = 1'b0; halt_req_i = 1'b0; resume_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Reset: kill all ones, stall still combinational, status low
    step("rst0", 1, 4'b0100, 4'b0000, 0, 0, 0, 4'b0111, 4'b1111, 0, 0, 0);
    step("rst1", 1, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 4'b1111, 0, 0, 0);

    // Stall fan-out
    step("stall_s2", 0, 4'b0100, 4'b0000, 0, 0, 0, 4'b0111, 4'b0000, 0, 0, 0);
    step("stall_s1", 0, 4'b0010, 4'b0000, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, 0);
    step("stall_s3", 0, 4'b1000, 4'b0000, 0, 0, 0, 4'b0111, 4'b0000, 0, 0, 0);
    step("stall_s0", 0, 4'b0001, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

    // Single taken branch, no stalls
    step("bra_t0", 0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 4'b0111, 0, 0, 0);
    step("bra_t1", 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0110, 0, 0, 0);
    step("bra_t2", 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0100, 0, 0, 0);
    step("bra_t3", 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

    // Branch followed by a three-cycle stall of the branch stage
    step("bst_t0", 0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 4'b0111, 0, 0, 0);
    step("bst_t1", 0, 4'b0100, 4'b0000, 0, 0, 0, 4'b0111, 4'b0110, 0, 0, 0);
    step("bst_t2", 0, 4'b0100, 4'b0000, 0, 0, 0, 4'b0111, 4'b0110, 0, 0, 0);
    step("bst_t3", 0, 4'b0100, 4'b0000, 0, 0, 0, 4'b0111, 4'b0110, 0, 0, 0);
    step("bst_t4", 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0110, 0, 0, 0);
    step("bst_t5", 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0100, 0, 0, 0);
    step("bst_t6", 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

    // Clean drain: request dropped early, resume ignored in DRAIN, halts once empty
    step("drn_req",  0, 4'b0000, 4'b1110, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 0);
    step("drn_c1",   0, 4'b0000, 4'b1100, 0, 0, 0, 4'b0000, 4'b0000, 1, 0, 0);
    step("drn_c2",   0, 4'b0000, 4'b1000, 0, 0, 1, 4'b0000, 4'b0000, 1, 0, 0);
    step("drn_c3",   0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 1, 0, 0);
    step("drn_halt", 0, 4'b0000, 4'b0000, 0, 0, 1, 4'b0000, 4'b0000, 1, 1, 0);
    step("drn_run",  0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

    // Drain timeout with the writeback stage stuck stalling
    step("to_req", 0, 4'b1000, 4'b0000, 0, 1, 0, 4'b0111, 4'b0000, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step($sformatf("to_d%0d", i), 0, 4'b1000, 4'b0000, 0, 1, 0, 4'b0111, 4'b0000, 1, 0, 0);
    end
    step("to_halt",   0, 4'b1000, 4'b0000, 0, 1, 1, 4'b0111, 4'b0000, 1, 1, 1);
    step("to_run",    0, 4'b1000, 4'b0000, 0, 1, 0, 4'b0111, 4'b0000, 0, 0, 1);
    step("to_redrn",  0, 4'b1000, 4'b0000, 0, 0, 1, 4'b0111, 4'b0000, 1, 0, 0);
    step("to_empty",  0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 1, 0, 0);
    step("to_halt2",  0, 4'b0000, 4'b0000, 0, 0, 1, 4'b0000, 4'b0000, 1, 1, 0);
    step("to_run2",   0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

    // Reset in the middle of a drain with live branch history
    step("rd_req",   0, 4'b0000, 4'b1110, 1, 1, 0, 4'b0000, 4'b0111, 0, 0, 0);
    step("rd_d0",    0, 4'b0000, 4'b1110, 0, 0, 0, 4'b0000, 4'b0110, 1, 0, 0);
    step("rd_d1",    0, 4'b0000, 4'b1110, 0, 0, 0, 4'b0000, 4'b0100, 1, 0, 0);
    step("rd_d2",    0, 4'b0000, 4'b1110, 1, 0, 0, 4'b0000, 4'b0111, 1, 0, 0);
    step("rd_rst",   1, 4'b0000, 4'b1110, 0, 0, 0, 4'b0000, 4'b1111, 0, 0, 0);
    step("rd_after", 0, 4'b0000, 4'b1110, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    step("rd_idle",  0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
